// File: rtl/truth_table_capture.sv
// truth_table_capture
// Self-test engine that sweeps every input combination 0 .. 2**N-1 onto a
// small combinational function, holds each vector for SETTLE cycles, records
// the function output into a 2**N-bit truth table and compares the finished
// table against an expected table latched when the capture started.
//
// Bit i of expected, table_out and mismatch always refers to input value i.
// dut_in drives the MSB as the first function input and the LSB as the last.
// Legal parameter ranges: N in 1..6, SETTLE >= 1.
// Every output comes straight from a register, so there is no combinational
// path from start, expected or dut_out to any output.

module truth_table_capture #(
    parameter int N      = 3,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2**N-1:0]   expected,
    output logic [N-1:0]      dut_in,
    input  logic              dut_out,
    output logic              busy,
    output logic              done,
    output logic [2**N-1:0]   table_out,
    output logic              pass,
    output logic [2**N-1:0]   mismatch
);

    // Table width, index width (one spare bit so the index never wraps
    // within a run) and settle counter width (at least one bit so that
    // SETTLE = 1 still gives a legal vector).
    localparam int TW = 2 ** N;
    localparam int IW = N + 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [IW-1:0] LAST_INDEX  = IW'(TW - 1);
    localparam logic [CW-1:0] LAST_SETTLE = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   index_q;
    logic [CW-1:0]   settleCnt_q;
    logic [TW-1:0]   expLatched_q;
    logic [TW-1:0]   table_q;
    logic [N-1:0]    dutIn_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic [TW-1:0]   mismatch_q;

    logic [TW-1:0]   tableCaptured_d;
    logic            sampleNow;
    logic            lastVector;

    // The table as it will look once the current dut_out sample is written;
    // used both to update the table and to score the final edge of a run.
    always_comb begin
        tableCaptured_d = table_q;
        tableCaptured_d[index_q[N-1:0]] = dut_out;
    end

    // Sample point of the current vector and detection of the final vector.
    always_comb begin
        sampleNow  = (settleCnt_q == LAST_SETTLE);
        lastVector = (index_q == LAST_INDEX);
    end

    // Capture state machine: all state and every output register live here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            index_q      <= '0;
            settleCnt_q  <= '0;
            expLatched_q <= '0;
            table_q      <= '0;
            dutIn_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            mismatch_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q      <= APPLY;
                        expLatched_q <= expected;
                        table_q      <= '0;
                        index_q      <= '0;
                        settleCnt_q  <= '0;
                        dutIn_q      <= '0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        mismatch_q   <= '0;
                    end
                end

                APPLY: begin
                    if (sampleNow) begin
                        table_q <= tableCaptured_d;
                        if (lastVector) begin
                            state_q    <= DONE;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            dutIn_q    <= '0;
                            pass_q     <= (tableCaptured_d == expLatched_q);
                            mismatch_q <= tableCaptured_d ^ expLatched_q;
                        end else begin
                            index_q     <= index_q + IW'(1);
                            dutIn_q     <= index_q[N-1:0] + N'(1);
                            settleCnt_q <= '0;
                        end
                    end else begin
                        settleCnt_q <= settleCnt_q + CW'(1);
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs are the registers themselves.
    assign dut_in    = dutIn_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign table_out = table_q;
    assign pass      = pass_q;
    assign mismatch  = mismatch_q;

endmodule

// File: tb/tb_truth_table_capture.sv
// Bench for truth_table_capture: one instance with default parameters and one
// with SETTLE = 3, each driving a bench-side function selected by a mode.
// Expected tables come from evaluating the selected function over all inputs.

module tb_truth_table_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start, sStart;
    logic [7:0] expected, sExpected;
    logic [2:0] dutIn, sDutIn;
    logic       dutOut, sDutOut;
    logic       busy, sBusy;
    logic       done, sDone;
    logic [7:0] tableOut, sTable;
    logic       pass, sPass;
    logic [7:0] mismatch, sMismatch;

    int         mode, sMode;
    logic [7:0] randTable;

    int checks = 0;
    int errors = 0;

    truth_table_capture #(.N(3), .SETTLE(1)) dut (
        .clk(clk), .reset(reset), .start(start), .expected(expected),
        .dut_in(dutIn), .dut_out(dutOut), .busy(busy), .done(done),
        .table_out(tableOut), .pass(pass), .mismatch(mismatch)
    );

    truth_table_capture #(.N(3), .SETTLE(3)) dutSlow (
        .clk(clk), .reset(reset), .start(sStart), .expected(sExpected),
        .dut_in(sDutIn), .dut_out(sDutOut), .busy(sBusy), .done(sDone),
        .table_out(sTable), .pass(sPass), .mismatch(sMismatch)
    );

    // Function under measurement, chosen by mode; inputs are a=v[2], b=v[1], c=v[0].
    function automatic logic funcVal(input int m, input logic [2:0] v, input logic [7:0] rt);
        logic a, b, c;
        a = v[2];
        b = v[1];
        c = v[0];
        case (m)
            0:       return (a & ~b) | (~b & ~c) | (~a & b & c);
            1:       return a;
            2:       return c;
            3:       return 1'b1;
            default: return rt[v];
        endcase
    endfunction

    // Reference truth table: the function evaluated at every input value.
    function automatic logic [7:0] refTable(input int m);
        logic [7:0] t;
        for (int i = 0; i < 8; i++) t[i] = funcVal(m, 3'(i), randTable);
        return t;
    endfunction

    always_comb dutOut  = funcVal(mode, dutIn, randTable);
    always_comb sDutOut = funcVal(sMode, sDutIn, randTable);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] want);
        checks++;
        if (observed !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, want, $time);
        end
    endtask

    // One capture on the default instance, checking the per-cycle timeline
    // and the final result; optionally pulses start mid-run.
    task automatic applyStimulus(input int m, input logic [7:0] exp,
                                 input logic [7:0] wantTable, input bit pulseStart);
        @(negedge clk);
        mode     = m;
        expected = exp;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        expected = 8'($urandom);
        for (int j = 0; j < 8; j++) begin
            checkOutput("dut_in", 32'(dutIn), 32'(j));
            checkOutput("busy", 32'(busy), 32'd1);
            checkOutput("done_early", 32'(done), 32'd0);
            start = pulseStart && (j == 2 || j == 5);
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput("done", 32'(done), 32'd1);
        checkOutput("busy_end", 32'(busy), 32'd0);
        checkOutput("dut_in_end", 32'(dutIn), 32'd0);
        checkOutput("table_out", 32'(tableOut), 32'(wantTable));
        checkOutput("pass", 32'(pass), 32'(wantTable == exp));
        checkOutput("mismatch", 32'(mismatch), 32'(wantTable ^ exp));
    endtask

    // One capture on the SETTLE = 3 instance with a bounded wait for done.
    task automatic applySlow(input int m, input logic [7:0] exp, input logic [7:0] wantTable);
        int n;
        @(negedge clk);
        sMode     = m;
        sExpected = exp;
        sStart    = 1'b1;
        @(negedge clk);
        sStart = 1'b0;
        n = 0;
        while (!sDone && n < 40) begin
            checkOutput("slow_dut_in", 32'(sDutIn), 32'(n / 3));
            n++;
            @(negedge clk);
        end
        checkOutput("slow_latency", 32'(n), 32'd24);
        checkOutput("slow_table", 32'(sTable), 32'(wantTable));
        checkOutput("slow_pass", 32'(sPass), 32'(wantTable == exp));
        checkOutput("slow_mismatch", 32'(sMismatch), 32'(wantTable ^ exp));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_dut_in"}, 32'(dutIn), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_table"}, 32'(tableOut), 32'd0);
        checkOutput({tag, "_pass"}, 32'(pass), 32'd0);
        checkOutput({tag, "_mismatch"}, 32'(mismatch), 32'd0);
    endtask

    initial begin
        logic [7:0] want;
        logic [7:0] exp;
        int         m;

        reset     = 1'b1;
        start     = 1'b0;
        sStart    = 1'b0;
        expected  = 8'hFF;
        sExpected = 8'hFF;
        mode      = 0;
        sMode     = 0;
        randTable = 8'h00;
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        checkOutput("slow_reset_busy", 32'(sBusy), 32'd0);
        checkOutput("slow_reset_table", 32'(sTable), 32'd0);
        reset = 1'b0;

        // Directed captures from the test plan.
        applyStimulus(0, 8'h39, 8'h39, 1'b0);
        applyStimulus(0, 8'h3B, 8'h39, 1'b0);
        applyStimulus(1, 8'h00, 8'hF0, 1'b0);
        applyStimulus(2, 8'hAA, 8'hAA, 1'b0);
        applyStimulus(0, 8'h39, 8'h39, 1'b1);

        // Reset in the middle of a run, then a clean run afterwards.
        @(negedge clk);
        mode     = 0;
        expected = 8'h39;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkAllZero("midreset");
        reset = 1'b0;
        applyStimulus(0, 8'h39, 8'h39, 1'b0);

        // Start held high while in DONE restarts immediately.
        start    = 1'b1;
        mode     = 1;
        expected = 8'hF0;
        @(negedge clk);
        checkOutput("restart_done", 32'(done), 32'd0);
        checkOutput("restart_busy", 32'(busy), 32'd1);
        checkOutput("restart_dut_in", 32'(dutIn), 32'd0);
        repeat (8) @(negedge clk);
        checkOutput("held_done", 32'(done), 32'd1);
        checkOutput("held_table", 32'(tableOut), 32'hF0);
        checkOutput("held_pass", 32'(pass), 32'd1);
        @(negedge clk);
        checkOutput("held_restart_done", 32'(done), 32'd0);
        checkOutput("held_restart_busy", 32'(busy), 32'd1);
        start = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("held_second_done", 32'(done), 32'd1);

        // Randomized functions and expected tables.
        for (int r = 0; r < 10; r++) begin
            m         = int'($urandom_range(0, 4));
            randTable = 8'($urandom);
            want      = refTable(m);
            exp       = ($urandom_range(0, 1) == 0) ? want : (want ^ 8'($urandom));
            applyStimulus(m, exp, want, 1'b0);
        end

        // Slow instance: constant one, then a random function.
        applySlow(3, 8'hFF, 8'hFF);
        randTable = 8'($urandom);
        want      = refTable(4);
        applySlow(4, 8'h5A, want);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_capture.md
# truth_table_capture

Sequential truth-table extractor for small combinational functions: the measuring counterpart to the mux-based truth-table implementations. On `start` it drives every input combination `0 .. 2**N-1` onto a combinational DUT. It waits `SETTLE` cycles per vector, records the DUT output into a `2**N`-bit truth table, and compares the result against an expected table. It sits beside function blocks on the board/bench as a self-test engine, so equivalence checks (mux form vs. SOP form) run in hardware without a simulator testbench.

## Interface
Parameters
- `N`, 3, number of DUT inputs; legal 1..6.
- `SETTLE`, 1, cycles each vector is held before sampling; legal >= 1 (0 is illegal).

Ports
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a capture; sampled only in IDLE or DONE.
- `expected` in `2**N`: expected truth table, bit i = output for input value i; latched at start.
- `dut_in` out N: vector driven to DUT, MSB = first function input (a), LSB = last (c).
- `dut_out` in 1: DUT output, assumed combinational/settled within `SETTLE` cycles.
- `busy` out 1: capture in progress.
- `done` out 1: capture complete, results valid; level, held until next start or reset.
- `table_out` out `2**N`: captured truth table, same bit ordering as `expected`.
- `pass` out 1: `table_out == expected_latched`; valid only while `done`.
- `mismatch` out `2**N`: `table_out ^ expected_latched`; valid only while `done`.

## Operation
- State machine: IDLE, APPLY, DONE.
- Reset (any state, mid-run included): state IDLE; `dut_in`=0, `busy`=0, `done`=0, `table_out`=0, `pass`=0, `mismatch`=0, index=0, settle counter=0, latched expected=0.
- IDLE: `start`=1 leads to APPLY; latch `expected`, clear `table_out`, index=0, settle counter=0, `dut_in`=0, `busy`=1.
- APPLY: `dut_in` = index. Settle counter counts 0..SETTLE-1. At the edge where counter == SETTLE-1:
  - Capture `dut_out` into `table_out[index]`.
  - If index == 2**N-1: go to DONE.
  - Otherwise index+1, counter 0.
- APPLY to DONE edge: `busy`=0, `done`=1, `dut_in` returns to 0. `pass` and `mismatch` are computed from the completed table, including the bit captured on that same edge.
- DONE: outputs held. `start`=1 restarts exactly as from IDLE; `done`, `pass` and `mismatch` clear on that edge.
- `start` during APPLY is ignored; no restart and no effect on timing.
- Index width is N+1 bits, or terminal compare at 2**N-1; there is no wrap-around to 0 within a run.
- `table_out` bits for not-yet-applied vectors read 0 during APPLY. They are not a valid result until `done`.

## Timing
- Let `start` be sampled high at edge k.
- Vector i is on `dut_in` during cycles [k + i*SETTLE, k + (i+1)*SETTLE). It is sampled at edge k + (i+1)*SETTLE.
- `busy` is high from edge k to edge k + 2**N*SETTLE, where it falls and `done` rises.
- Latency from start to done is 2**N*SETTLE cycles: 8 for the defaults.
- All outputs are registered; no combinational path from `start`, `expected` or `dut_out` to any output.

## Test plan
- DUT `y = a&~b | ~b&~c | ~a&b&c`, `expected`=8'h39, defaults: `dut_in` steps 0..7 one per cycle. `done` 8 cycles after start; `table_out`=8'h39, `pass`=1, `mismatch`=8'h00.
- Same DUT, `expected`=8'h3B: `table_out`=8'h39, `pass`=0, `mismatch`=8'h02.
- Ordering check, DUT `y=a` (`dut_in[2]`): `table_out`=8'hF0. DUT `y=c`: `table_out`=8'hAA.
- `SETTLE`=3, DUT constant 1: each `dut_in` value held 3 cycles. `done` at 24 cycles, `table_out`=8'hFF.
- `reset` asserted 4 cycles into a run: next edge all outputs are 0 and state is IDLE. A following start completes a full 8-cycle run with correct results.
- `start` pulsed at cycles 2 and 5 of a run: ignored, `done` still at cycle 8. `start` held high in DONE: `done` drops and a new capture begins the next cycle.
